reg_read_arbiter: RTL
=====================

REG_READ_ARBITER -- requirements
Module: reg_read_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, register/data width.
REQ-002 Parameter: ADDR_W, default 3, register address width (8 registers).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  4  per-requester read request; bit i belongs to requester i.
REQ-006 Port: addr0..addr3  input  ADDR_W each  register address of requester i, valid while req[i]=1.
REQ-007 Port: Addr  output  ADDR_W  address driven to the register-file read mux.
REQ-008 Port: Data  input  DATA_W  combinational read data returned by the read mux for Addr.
REQ-009 Port: ack  output  4  one-hot read-complete pulse; ack[i]=1 means rdata holds requester i's data.
REQ-010 Port: rdata  output  DATA_W  registered read data.
REQ-011 Port: gnt_id  output  2  index of the requester granted in the current cycle; meaningful only when gnt_vld=1.
REQ-012 Port: gnt_vld  output  1  a grant is issued this cycle.

Function
REQ-013 Arbiter SHALL share the single read port among 4 requesters, at most one grant per cycle.
REQ-014 Eligible set in cycle N SHALL be req & ~ack; the requester currently acked is masked to prevent a duplicate read.
REQ-015 Grant SHALL be combinational: gnt_vld=1 in any cycle with a non-empty eligible set, gnt_id = winner.
REQ-016 Addr SHALL equal addr[gnt_id] when gnt_vld=1, else all zeros.
REQ-017 On the edge ending a grant cycle, rdata SHALL capture Data and ack SHALL be set to one-hot(gnt_id); latency request-to-ack is exactly 1 cycle.
REQ-018 ack SHALL be a single-cycle pulse; with no grant in cycle N, ack=0 in N+1 and rdata SHALL hold its previous value.
REQ-019 Requester i SHALL keep req[i] and addr i stable until ack[i]; deasserting req before ack cancels the request with no ack issued.
REQ-020 Round-robin pointer last_id (2 bits) SHALL update to gnt_id on every grant; search order is last_id+1, +2, +3, +4 modulo 4 (wrap 3->0).
REQ-021 A single persistent requester SHALL obtain one read every 2 cycles; two or more persistent requesters SHALL obtain back-to-back grants every cycle.
REQ-022 Requests arriving while another is granted SHALL wait, bounded by 3 grants to others (no starvation).

Reset
REQ-023 While reset=1: ack=0, rdata=0, last_id=3, gnt_vld=0, Addr=0; requests are ignored.
REQ-024 Reset asserted mid-operation SHALL discard any pending ack; first post-reset grant favours requester 0.

Configuration
REQ-025 Macro ROUND_ROBIN_EN: when defined, arbitration per REQ-020/REQ-022.
REQ-026 When ROUND_ROBIN_EN is undefined, fixed priority SHALL apply (requester 0 highest, 3 lowest), last_id SHALL be absent, and REQ-022 does not hold; all other requirements unchanged.

Verification
REQ-027 Reset, then req=0001, addr0=5, reg5=0xDEADBEEF -> gnt_vld=1, Addr=5 in cycle 1; ack=0001, rdata=0xDEADBEEF in cycle 2.
REQ-028 req=1111 held, addrs 0,1,2,3 -> grants in order 0,1,2,3,0 on consecutive cycles; acks follow one cycle later.
REQ-029 req=0001 held continuously -> ack[0] pulses every other cycle; gnt_vld=0 in each ack cycle.
REQ-030 Grant to requester 2 in cycle N, reset=1 in cycle N+1 -> ack=0, rdata=0 in N+1 and N+2; next grant with req=1111 goes to 0.
REQ-031 ROUND_ROBIN_EN undefined, req=0011 held -> requester 0 granted on every eligible cycle, requester 1 only in ack[0] cycles.

Source files
------------

// File: rtl/reg_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_arbiter
// Purpose  : Shares one register-file read port among four requesters.
//            Grants are combinational; ack and rdata follow one cycle later.
//            Define ROUND_ROBIN_EN for round-robin arbitration; otherwise
//            fixed priority (requester 0 highest).
// Revision : 1.0
// ============================================================================
module reg_read_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    output logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data,
    output logic [3:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt_id,
    output logic              gnt_vld
);

    logic [3:0]        r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic [3:0]        w_elig;
    logic [1:0]        w_gnt_id;
    logic              w_gnt_vld;
    logic [ADDR_W-1:0] w_addr_sel;

    // The requester being acked this cycle is masked so it cannot be read twice.
    assign w_elig = reset ? 4'b0000 : (req & ~r_ack);

`ifdef ROUND_ROBIN_EN
    logic [1:0] r_last_id;

    // Descending scan so the closest position after r_last_id wins.
    always_comb begin
        logic [1:0] w_idx;
        w_idx     = 2'd0;
        w_gnt_id  = 2'd0;
        w_gnt_vld = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last_id + 2'(k);
            if (w_elig[w_idx]) begin
                w_gnt_id  = w_idx;
                w_gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_id <= 2'd3;
        end else if (w_gnt_vld) begin
            r_last_id <= w_gnt_id;
        end
    end
`else
    always_comb begin
        w_gnt_id  = 2'd0;
        w_gnt_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_gnt_id  = 2'(i);
                w_gnt_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_addr_sel = '0;
        case (w_gnt_id)
            2'd0:    w_addr_sel = addr0;
            2'd1:    w_addr_sel = addr1;
            2'd2:    w_addr_sel = addr2;
            default: w_addr_sel = addr3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 4'b0000;
            r_rdata <= '0;
        end else begin
            r_ack <= w_gnt_vld ? (4'b0001 << w_gnt_id) : 4'b0000;
            if (w_gnt_vld) begin
                r_rdata <= Data;
            end
        end
    end

    // Outputs read as idle for the whole time reset is high, including the
    // cycle in which a pending ack would otherwise still be visible.
    assign gnt_vld = w_gnt_vld;
    assign gnt_id  = w_gnt_id;
    assign Addr    = w_gnt_vld ? w_addr_sel : '0;
    assign ack     = reset ? 4'b0000 : r_ack;
    assign rdata   = reset ? '0 : r_rdata;

endmodule
`default_nettype wire
